// File: rtl/keccak_pkg.sv
// keccak_pkg: shared widths, round count and controller state encoding for the SHA3-256 sponge front end
package keccak_pkg;
    localparam int WORD_W          = 136;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int RATE_W          = WORD_W * WORDS_PER_BLOCK;
    localparam int DIGEST_W        = 256;
    localparam int ROUNDS          = 24;
    typedef enum logic [2:0] {LOAD, START, PERM, OUT, ERR} state_t;
endpackage

// File: rtl/keccak_block_buf.sv
// keccak_block_buf: eight-slot rate block buffer
// Ports: clk, reset (async active-low clear), wr_en (one-hot slot select),
// wr_data (word to store), blk_data (flat block, slot k at bits 136k+135:136k).
module keccak_block_buf
    import keccak_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WORDS_PER_BLOCK-1:0] wr_en,
    input  logic [WORD_W-1:0]          wr_data,
    output logic [RATE_W-1:0]          blk_data
);
    for (genvar k = 0; k < WORDS_PER_BLOCK; k++) begin : g_slot
        logic [WORD_W-1:0] q;
        always_ff @(posedge clk or negedge reset)
            if (!reset) q <= '0;
            else if (wr_en[k]) q <= wr_data;
        assign blk_data[k*WORD_W +: WORD_W] = q;
    end
endmodule

// File: rtl/keccak_sponge_ctrl.sv
// keccak_sponge_ctrl: collects rate blocks, sequences the permutation core and returns the digest
// Ports: clk, reset (async active-low); in_valid/in_ready/in_data/in_last host word stream;
// blk_data/perm_start/state_clear to the core, perm_done/perm_digest from it;
// dig_valid/dig_ready/dig_data digest stream; busy status; err one-cycle error pulse.
module keccak_sponge_ctrl
    import keccak_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_last,
    output logic [RATE_W-1:0]   blk_data,
    output logic                perm_start,
    output logic                state_clear,
    input  logic                perm_done,
    input  logic [DIGEST_W-1:0] perm_digest,
    output logic                dig_valid,
    input  logic                dig_ready,
    output logic [DIGEST_W-1:0] dig_data,
    output logic                busy,
    output logic                err
);
    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    state_t                     state, state_nx;
    logic [2:0]                 word_cnt;
    logic                       first_blk, last_blk;
    logic [TIMER_W-1:0]         timer;
    logic                       accept, last_word, bad_last, wr_ok;
    logic [WORDS_PER_BLOCK-1:0] wr_en;

    assign accept    = in_valid && state == LOAD;
    assign last_word = word_cnt == 3'(WORDS_PER_BLOCK - 1);
    // in_last anywhere but the final slot is a framing error; that word is dropped
    assign bad_last  = accept && in_last && !last_word;
    assign wr_ok     = accept && !bad_last;
    assign wr_en     = wr_ok ? WORDS_PER_BLOCK'(1) << word_cnt : '0;

    keccak_block_buf u_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (in_data),
        .blk_data (blk_data)
    );

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    state_nx = bad_last ? ERR : (wr_ok && last_word) ? START : LOAD;
            START:   state_nx = PERM;
            // a done pulse in the timeout cycle still completes the block
            PERM:    state_nx = perm_done ? (last_blk ? OUT : LOAD) : (timer == TIMER_W'(TIMEOUT)) ? ERR : PERM;
            OUT:     state_nx = dig_ready ? LOAD : OUT;
            ERR:     state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD;
            word_cnt  <= '0;
            first_blk <= 1'b1;
            last_blk  <= 1'b0;
            timer     <= '0;
            dig_data  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                LOAD: if (wr_ok) begin
                    word_cnt <= word_cnt + 3'd1;
                    if (last_word) last_blk <= in_last;
                end
                START: timer <= '0;
                PERM: begin
                    timer <= timer + TIMER_W'(1);
                    if (perm_done && last_blk) dig_data <= perm_digest;
                    if (perm_done && !last_blk) first_blk <= 1'b0;
                end
                OUT: if (dig_ready) begin
                    first_blk <= 1'b1;
                    last_blk  <= 1'b0;
                end
                ERR: begin
                    word_cnt  <= '0;
                    first_blk <= 1'b1;
                    last_blk  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = state == LOAD;
    assign perm_start  = state == START;
    assign state_clear = state == START && first_blk;
    assign dig_valid   = state == OUT;
    assign err         = state == ERR;
    assign busy        = !(state == LOAD && word_cnt == 3'd0 && first_blk);
endmodule
